// File: rtl/onehot_pos_tracker_pkg.sv
// ----------------------------------------------------------------------------
// onehot_pos_tracker_pkg
// Shared definitions for the one-hot position tracker and for any other block
// that consumes the upstream one-hot position counter.
//   - state_e       : tracker FSM state encoding (IDLE, TRACK, ERROR)
//   - ERR_*         : error cause codes reported on err_code_o
//   - DEF_WIDTH     : default number of one-hot position bits
//   - DEF_LAP_W     : default lap counter width
// ----------------------------------------------------------------------------
package onehot_pos_tracker_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LAP_W = 8;

    // Error cause codes; 2'b11 is left unused for a future cause.
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MULTI = 2'b01;
    localparam logic [1:0] ERR_SEQ   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

endpackage : onehot_pos_tracker_pkg

// File: rtl/onehot_pos_tracker_classify.sv
// ----------------------------------------------------------------------------
// onehot_classify
// Purely combinational classifier for a one-hot position vector. Reusable by
// any consumer of the upstream position counter.
// Ports:
//   pos_i      in  [WIDTH-1:0]  position vector to classify
//   is_zero_o  out              no bit set
//   is_onehot_o out             exactly one bit set
//   is_multi_o out              two or more bits set
//   bin_o      out [IDX_W-1:0]  index of the set bit (valid when is_onehot_o)
// ----------------------------------------------------------------------------
module onehot_classify
    import onehot_pos_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] pos_i,
    output logic             is_zero_o,
    output logic             is_onehot_o,
    output logic             is_multi_o,
    output logic [IDX_W-1:0] bin_o
);

    // Clearing the lowest set bit leaves zero only when at most one bit was
    // set, which separates one-hot from multi-hot without a popcount.
    // The index is an OR of the positions of all set bits; it is only
    // meaningful when the vector is one-hot.
    always_comb begin
        is_zero_o   = (pos_i == '0);
        is_onehot_o = !is_zero_o && ((pos_i & (pos_i - WIDTH'(1))) == '0);
        is_multi_o  = !is_zero_o && !is_onehot_o;
        bin_o       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos_i[i]) begin
                bin_o = bin_o | IDX_W'(i);
            end
        end
    end

endmodule : onehot_classify

// File: rtl/onehot_pos_tracker.sv
// ----------------------------------------------------------------------------
// onehot_pos_tracker
// Follows the upstream one-hot position counter: encodes the position to a
// binary index, checks that each position is the legal successor (or a stall)
// of the previous one, counts completed laps and latches the first error.
// All outputs are registered (1 clk latency from pos_i).
// Ports:
//   clk          in                 system clock, rising edge
//   rst_n        in                 asynchronous active-low reset
//   pos_i        in  [WIDTH-1:0]    one-hot position from upstream counter
//   clr_err_i    in                 clears sticky error, returns to IDLE
//   idx_o        out [IDX_W-1:0]    binary index of last accepted position
//   idx_valid_o  out                idx_o reflects a tracked position
//   lap_tick_o   out                one-cycle pulse on WIDTH-1 -> 0 wrap
//   lap_cnt_o    out [LAP_W-1:0]    completed laps, modulo 2^LAP_W
//   err_o        out                sticky error flag
//   err_code_o   out [1:0]          first error cause (ERR_* codes)
// ----------------------------------------------------------------------------
module onehot_pos_tracker
    import onehot_pos_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int LAP_W = DEF_LAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pos_i,
    input  logic             clr_err_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_valid_o,
    output logic             lap_tick_o,
    output logic [LAP_W-1:0] lap_cnt_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    logic             is_zero;
    logic             is_onehot;
    logic             is_multi;
    logic [IDX_W-1:0] bin;
    logic [IDX_W-1:0] expected;

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             lap_tick_q,  lap_tick_d;
    logic [LAP_W-1:0] lap_cnt_q,   lap_cnt_d;
    logic             err_q,       err_d;
    logic [1:0]       err_code_q,  err_code_d;

    onehot_classify #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_classify (
        .pos_i       (pos_i),
        .is_zero_o   (is_zero),
        .is_onehot_o (is_onehot),
        .is_multi_o  (is_multi),
        .bin_o       (bin)
    );

    // Next-state logic for the tracker. idx_q doubles as the previous accepted
    // index, since it only changes when a position is accepted. The explicit
    // wrap on the expected successor keeps non-power-of-two widths correct.
    // A newly detected error always takes priority over clr_err_i, because
    // clr_err_i is only honoured in ERROR.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        lap_tick_d  = 1'b0;
        lap_cnt_d   = lap_cnt_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        expected    = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (is_multi) begin
                    state_d     = ST_ERROR;
                    idx_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_MULTI;
                end else if (is_onehot) begin
                    state_d     = ST_TRACK;
                    idx_d       = bin;
                    idx_valid_d = 1'b1;
                end else begin
                    idx_valid_d = 1'b0;
                end
            end

            ST_TRACK: begin
                if (is_multi) begin
                    state_d     = ST_ERROR;
                    idx_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_MULTI;
                end else if (is_zero) begin
                    state_d     = ST_IDLE;
                    idx_valid_d = 1'b0;
                end else if (bin == expected) begin
                    idx_d = bin;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        lap_tick_d = 1'b1;
                        lap_cnt_d  = lap_cnt_q + LAP_W'(1);
                    end
                end else if (bin != idx_q) begin
                    state_d     = ST_ERROR;
                    idx_valid_d = 1'b0;
                    err_d       = 1'b1;
                    err_code_d  = ERR_SEQ;
                end
            end

            ST_ERROR: begin
                idx_valid_d = 1'b0;
                err_d       = 1'b1;
                if (clr_err_i) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                idx_valid_d = 1'b0;
            end
        endcase
    end

    // All tracker state, including the outputs, is held here so that an
    // asynchronous reset clears everything at once, even a lap tick in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            lap_tick_q  <= 1'b0;
            lap_cnt_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            lap_tick_q  <= lap_tick_d;
            lap_cnt_q   <= lap_cnt_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign idx_o       = idx_q;
    assign idx_valid_o = idx_valid_q;
    assign lap_tick_o  = lap_tick_q;
    assign lap_cnt_o   = lap_cnt_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule : onehot_pos_tracker

// File: tb/tb_onehot_pos_tracker.sv
// ----------------------------------------------------------------------------
// tb_onehot_pos_tracker
// Directed bench for onehot_pos_tracker: walks the position counter through
// laps, stalls, multi-hot and skip errors, error clear, async reset and lap
// counter wrap, checking every output against hand-computed values.
// ----------------------------------------------------------------------------
module tb_onehot_pos_tracker;

    logic       clk;
    logic       rst_n;
    logic [7:0] pos_i;
    logic       clr_err_i;
    logic [2:0] idx_o;
    logic       idx_valid_o;
    logic       lap_tick_o;
    logic [7:0] lap_cnt_o;
    logic       err_o;
    logic [1:0] err_code_o;

    int checks;
    int errors;

    onehot_pos_tracker #(
        .WIDTH (8),
        .IDX_W (3),
        .LAP_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pos_i       (pos_i),
        .clr_err_i   (clr_err_i),
        .idx_o       (idx_o),
        .idx_valid_o (idx_valid_o),
        .lap_tick_o  (lap_tick_o),
        .lap_cnt_o   (lap_cnt_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one input vector, let one rising edge sample it, then settle 1 ns
    // past the edge so outputs are read away from the clock.
    task automatic applyStimulus(input logic [7:0] pos, input logic clr);
        pos_i     = pos;
        clr_err_i = clr;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Compares every output at once against the expected tuple.
    task automatic checkAll(input string tag, input int e_idx, input int e_valid,
                            input int e_tick, input int e_lap, input int e_err,
                            input int e_code);
        checkOutput({tag, ".idx"},      int'(idx_o),       e_idx);
        checkOutput({tag, ".valid"},    int'(idx_valid_o), e_valid);
        checkOutput({tag, ".tick"},     int'(lap_tick_o),  e_tick);
        checkOutput({tag, ".lap"},      int'(lap_cnt_o),   e_lap);
        checkOutput({tag, ".err"},      int'(err_o),       e_err);
        checkOutput({tag, ".code"},     int'(err_code_o),  e_code);
    endtask

    // Directed scenario sequence; each step lists the outputs expected one
    // clock after the stimulus.
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        pos_i     = 8'h00;
        clr_err_i = 1'b0;

        #3;
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lap from IDLE: 00, then 01..80, then wrap back to 01.
        $display("[TB] lap walk");
        applyStimulus(8'h00, 1'b0);
        checkAll("idle_zero", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(1 << i), 1'b0);
            checkAll("walk", i, 1, 0, 0, 0, 0);
        end
        applyStimulus(8'h01, 1'b0);
        checkAll("wrap1", 0, 1, 1, 1, 0, 0);
        applyStimulus(8'h01, 1'b0);
        checkAll("stall0", 0, 1, 0, 1, 0, 0);

        // Multi-hot while tracking at idx 2; later input must not overwrite.
        $display("[TB] multi-hot");
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h04, 1'b0);
        checkAll("at2", 2, 1, 0, 1, 0, 0);
        applyStimulus(8'h03, 1'b0);
        checkAll("multi", 2, 0, 0, 1, 1, 1);
        applyStimulus(8'h10, 1'b0);
        checkAll("multi_hold", 2, 0, 0, 1, 1, 1);

        // Clear with pos 0x80 ignored, then resync at 0x20.
        $display("[TB] clear and resync");
        applyStimulus(8'h80, 1'b1);
        checkAll("clear", 2, 0, 0, 1, 0, 0);
        applyStimulus(8'h20, 1'b0);
        checkAll("resync", 5, 1, 0, 1, 0, 0);

        // Zero input returns to IDLE, idx held.
        applyStimulus(8'h40, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkAll("to_idle", 6, 0, 0, 1, 0, 0);

        // Skip error from idx 2 to 0x10.
        $display("[TB] sequence skip");
        applyStimulus(8'h04, 1'b0);
        checkAll("enter2", 2, 1, 0, 1, 0, 0);
        applyStimulus(8'h10, 1'b0);
        checkAll("skip", 2, 0, 0, 1, 1, 2);
        applyStimulus(8'h00, 1'b1);
        checkAll("clear2", 2, 0, 0, 1, 0, 0);

        // Stall on 0x08 for three clocks: no error, no tick.
        applyStimulus(8'h04, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h08, 1'b0);
            checkAll("stall3", 3, 1, 0, 1, 0, 0);
        end

        // Skip with clr_err_i in the same cycle: the error wins.
        $display("[TB] error vs clear");
        applyStimulus(8'h10, 1'b0);
        checkAll("at4", 4, 1, 0, 1, 0, 0);
        applyStimulus(8'h40, 1'b1);
        checkAll("err_wins", 4, 0, 0, 1, 1, 2);
        applyStimulus(8'h00, 1'b1);
        checkAll("clear3", 4, 0, 0, 1, 0, 0);

        // Two more laps to reach lap count 3, ending on the wrap edge.
        $display("[TB] async reset");
        applyStimulus(8'h01, 1'b0);
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 1; i < 8; i++) applyStimulus(8'(1 << i), 1'b0);
            applyStimulus(8'h01, 1'b0);
        end
        checkAll("lap3", 0, 1, 1, 3, 0, 0);

        // Reset between edges while lap_tick_o is high.
        #3 rst_n = 1'b0;
        #1;
        checkAll("async_rst", 0, 0, 0, 0, 0, 0);
        pos_i = 8'h00;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 1'b0);
        checkAll("post_rst", 0, 1, 0, 0, 0, 0);

        // 255 laps, then one more wraps the lap counter to 0.
        $display("[TB] lap counter wrap");
        for (int lap = 0; lap < 255; lap++) begin
            for (int i = 1; i < 8; i++) applyStimulus(8'(1 << i), 1'b0);
            applyStimulus(8'h01, 1'b0);
        end
        checkAll("lap255", 0, 1, 1, 255, 0, 0);
        for (int i = 1; i < 8; i++) applyStimulus(8'(1 << i), 1'b0);
        checkAll("pre_wrap", 7, 1, 0, 255, 0, 0);
        applyStimulus(8'h01, 1'b0);
        checkAll("lap_wrap", 0, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_onehot_pos_tracker
